rxfifo: RTL and testbench
=========================

RXFIFO -- requirements
Module: rxfifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning receive character width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, 2..64.
REQ-003 SHALL have port i_Pclk, input, 1, meaning system clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port i_Data, input, DATA_W, meaning received character from the upstream receive shifter.
REQ-006 SHALL have port i_Done, input, 1, meaning character-complete from the shifter; level, may stay high for multiple cycles.
REQ-007 SHALL have port i_Rd, input, 1, meaning pop strobe from the host; one pop per high cycle.
REQ-008 SHALL have port i_Clr_Ovr, input, 1, meaning clear overrun flag.
REQ-009 SHALL have port o_Data, output, DATA_W, meaning head entry (first-word-fall-through).
REQ-010 SHALL have port o_Empty, output, 1, meaning FIFO holds zero entries.
REQ-011 SHALL have port o_Full, output, 1, meaning FIFO holds DEPTH entries.
REQ-012 SHALL have port o_Count, output, log2(DEPTH)+1, meaning current occupancy.
REQ-013 SHALL have port o_Overrun, output, 1, meaning sticky character-lost flag.

Function
REQ-014 SHALL register i_Done and generate a one-cycle push on its 0->1 transition only; held-high i_Done SHALL NOT cause repeated pushes.
REQ-015 SHALL write i_Data, sampled in the push cycle, at the write pointer; entry visible on o_Data/o_Count one cycle after the push cycle.
REQ-016 SHALL advance pointers modulo DEPTH; wrap from DEPTH-1 to 0 with no gap or duplicate.
REQ-017 SHALL present the head entry on o_Data combinationally from the array; o_Data SHALL be 0 when o_Empty.
REQ-018 SHALL pop on i_Rd when not empty; i_Rd on empty SHALL be ignored (no pointer/count change, no error).
REQ-019 SHALL, on push when full with no simultaneous pop, discard the character, leave contents unchanged and set o_Overrun.
REQ-020 SHALL, on simultaneous push and pop when full, perform both; count stays DEPTH; o_Overrun unchanged.
REQ-021 SHALL, on simultaneous push and pop when empty, perform only the push; count becomes 1.
REQ-022 SHALL, on simultaneous push and pop otherwise, perform both; count unchanged.
REQ-023 SHALL derive o_Empty (count==0) and o_Full (count==DEPTH) from registered count, no combinational path from inputs.
REQ-024 SHALL clear o_Overrun on i_Clr_Ovr; if set and clear coincide, set SHALL win.

Reset
REQ-025 SHALL, on i_Rst_n low, asynchronously force pointers=0, count=0, o_Empty=1, o_Full=0, o_Overrun=0, o_Data=0, registered i_Done=0.
REQ-026 SHALL, on reset mid-operation, discard all stored entries; array contents need not be cleared.
REQ-027 SHALL NOT push on the first cycle after reset release even if i_Done is already high.

Configuration
REQ-028 SHALL, with macro RXFIFO_OVERRUN_EN defined, implement REQ-019/REQ-024 overrun flag logic.
REQ-029 SHALL, without RXFIFO_OVERRUN_EN, tie o_Overrun to 0, ignore i_Clr_Ovr, and still discard push-when-full characters.

Structure
REQ-030 SHALL place DATA_W default, DEPTH default and pointer-width function in shared package usrt_pkg.
REQ-031 SHALL isolate the storage array in sub-module rxfifo_mem (one write port, one async read port).

Verification
REQ-032 SHALL test: reset, then i_Done pulse with i_Data=0xA5 -> next cycle o_Data=0xA5, o_Count=1, o_Empty=0.
REQ-033 SHALL test: i_Done held high 20 cycles with 0x3C -> exactly one entry stored, o_Count=1.
REQ-034 SHALL test: 8 pushes 0x01..0x08 then 9th 0xFF -> o_Full=1, o_Overrun=1, pops return 0x01..0x08, then o_Empty=1.
REQ-035 SHALL test: full FIFO, push 0x55 with i_Rd same cycle -> o_Count=8, o_Overrun=0, last pop returns 0x55; 20 push/pop cycles verify wrap.
REQ-036 SHALL test: i_Rd on empty -> no change; push with simultaneous i_Rd on empty -> o_Count=1.
REQ-037 SHALL test: i_Rst_n low mid-fill with 3 entries -> o_Count=0, o_Empty=1 immediately, asynchronously to i_Pclk; build without RXFIFO_OVERRUN_EN -> o_Overrun stays 0 in REQ-034.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared defaults and helpers for the receive-side blocks.
package usrt_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 8;

   // Address width for a power-of-two array; never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/rxfifo_mem.sv
// Receive FIFO storage: one synchronous write port and one asynchronous read port.
module rxfifo_mem
   import usrt_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int AW     = ptr_w(DEPTH)
) (
   input  logic              i_Pclk,
   input  logic              i_We,
   input  logic [AW-1:0]     i_Waddr,
   input  logic [DATA_W-1:0] i_Wdata,
   input  logic [AW-1:0]     i_Raddr,
   output logic [DATA_W-1:0] o_Rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Contents are left uninitialised; occupancy tracking in the top hides stale data.
   always_ff @(posedge i_Pclk) begin
      if (i_We) r_mem[i_Waddr] <= i_Wdata;
   end

   assign o_Rdata = r_mem[i_Raddr];

endmodule

// File: rtl/rxfifo.sv
// Receive character FIFO, first-word-fall-through, edge-detected push.
// Optional sticky overrun flag enabled by defining RXFIFO_OVERRUN_EN.
module rxfifo
   import usrt_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int AW     = ptr_w(DEPTH),
   localparam int CW     = AW + 1
) (
   input  logic              i_Pclk,
   input  logic              i_Rst_n,
   input  logic [DATA_W-1:0] i_Data,
   input  logic              i_Done,
   input  logic              i_Rd,
   input  logic              i_Clr_Ovr,
   output logic [DATA_W-1:0] o_Data,
   output logic              o_Empty,
   output logic              o_Full,
   output logic [CW-1:0]     o_Count,
   output logic              o_Overrun
);

   logic              r_done;
   logic              r_armed;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic              w_push;
   logic              w_pop;
   logic              w_wr;
   logic              w_empty;
   logic              w_full;
   logic [DATA_W-1:0] w_rdata;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));

   // r_armed masks the first edge after reset so an already-high i_Done is not taken as a new character.
   assign w_push = i_Done & ~r_done & r_armed;
   assign w_pop  = i_Rd & ~w_empty;
   assign w_wr   = w_push & (~w_full | w_pop);

   always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_done   <= 1'b0;
         r_armed  <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_done  <= i_Done;
         r_armed <= 1'b1;
         if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   rxfifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .i_Pclk  (i_Pclk),
      .i_We    (w_wr),
      .i_Waddr (r_wr_ptr),
      .i_Wdata (i_Data),
      .i_Raddr (r_rd_ptr),
      .o_Rdata (w_rdata)
   );

   assign o_Data  = w_empty ? '0 : w_rdata;
   assign o_Empty = w_empty;
   assign o_Full  = w_full;
   assign o_Count = r_count;

`ifdef RXFIFO_OVERRUN_EN
   logic r_ovr;
   logic w_ovr_set;

   assign w_ovr_set = w_push & w_full & ~w_pop;

   // A lost character in the same cycle as a clear keeps the flag set.
   always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
      if (!i_Rst_n)       r_ovr <= 1'b0;
      else if (w_ovr_set) r_ovr <= 1'b1;
      else if (i_Clr_Ovr) r_ovr <= 1'b0;
   end

   assign o_Overrun = r_ovr;
`else
   logic w_unused_clr;

   assign w_unused_clr = i_Clr_Ovr;
   assign o_Overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_rxfifo.sv
// Directed bench for rxfifo: vector table plus hand-written multi-cycle sequences.
module tb_rxfifo;

`ifdef RXFIFO_OVERRUN_EN
   localparam logic OVR_EN = 1'b1;
`else
   localparam logic OVR_EN = 1'b0;
`endif

   logic       i_Pclk;
   logic       i_Rst_n;
   logic [7:0] i_Data;
   logic       i_Done;
   logic       i_Rd;
   logic       i_Clr_Ovr;
   logic [7:0] o_Data;
   logic       o_Empty;
   logic       o_Full;
   logic [3:0] o_Count;
   logic       o_Overrun;

   int n_tests = 0;
   int n_fail  = 0;

   rxfifo #(.DATA_W(8), .DEPTH(8)) dut (
      .i_Pclk    (i_Pclk),
      .i_Rst_n   (i_Rst_n),
      .i_Data    (i_Data),
      .i_Done    (i_Done),
      .i_Rd      (i_Rd),
      .i_Clr_Ovr (i_Clr_Ovr),
      .o_Data    (o_Data),
      .o_Empty   (o_Empty),
      .o_Full    (o_Full),
      .o_Count   (o_Count),
      .o_Overrun (o_Overrun)
   );

   initial i_Pclk = 1'b0;
   always #5 i_Pclk = ~i_Pclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       done;
      logic       rd;
      logic [7:0] data;
      int         cnt;
      logic       emp;
      logic       ful;
      logic [7:0] hd;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string name, input int cnt, input logic emp,
                            input logic ful, input logic [7:0] hd, input logic ovr);
      chk({name, ".count"},   32'(o_Count),   32'(cnt));
      chk({name, ".empty"},   32'(o_Empty),   32'(emp));
      chk({name, ".full"},    32'(o_Full),    32'(ful));
      chk({name, ".data"},    32'(o_Data),    32'(hd));
      chk({name, ".overrun"}, 32'(o_Overrun), 32'(ovr));
   endtask

   task automatic tick();
      @(posedge i_Pclk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      i_Data = d;
      i_Done = 1'b1;
      tick();
      i_Done = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      i_Rst_n = 1'b0;
      tick();
      i_Rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] nd;

      tbl[0]  = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 1'b0, 8'hA5, 1, 1'b0, 1'b0, 8'hA5};
      tbl[2]  = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'hA5};
      tbl[3]  = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h00};
      tbl[4]  = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h00};
      tbl[5]  = '{1'b1, 1'b1, 8'h77, 1, 1'b0, 1'b0, 8'h77};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 8'h77};
      tbl[7]  = '{1'b1, 1'b0, 8'h88, 2, 1'b0, 1'b0, 8'h77};
      tbl[8]  = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 8'h88};
      tbl[9]  = '{1'b1, 1'b1, 8'h99, 1, 1'b0, 1'b0, 8'h99};
      tbl[10] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h00};

      i_Rst_n = 1'b0; i_Data = '0; i_Done = 1'b0; i_Rd = 1'b0; i_Clr_Ovr = 1'b0;
      tick();
      tick();
      chk_state("reset", 0, 1'b1, 1'b0, 8'h00, 1'b0);
      i_Rst_n = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         i_Done = tbl[i].done;
         i_Rd   = tbl[i].rd;
         i_Data = tbl[i].data;
         tick();
         chk_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].emp, tbl[i].ful, tbl[i].hd, 1'b0);
      end
      i_Done = 1'b0; i_Rd = 1'b0;

      // i_Done held high for 20 cycles stores exactly one character.
      i_Data = 8'h3C;
      i_Done = 1'b1;
      repeat (20) tick();
      chk_state("held_done", 1, 1'b0, 1'b0, 8'h3C, 1'b0);
      i_Done = 1'b0;
      i_Rd   = 1'b1;
      tick();
      i_Rd   = 1'b0;
      chk_state("held_done_pop", 0, 1'b1, 1'b0, 8'h00, 1'b0);

      // Fill, overflow, flag set/clear priority, then drain.
      do_reset();
      for (int i = 1; i <= 8; i++) push(8'(i));
      chk_state("fill8", 8, 1'b0, 1'b1, 8'h01, 1'b0);
      push(8'hFF);
      chk_state("ovf", 8, 1'b0, 1'b1, 8'h01, OVR_EN);
      i_Data = 8'hEE; i_Done = 1'b1; i_Clr_Ovr = 1'b1;
      tick();
      i_Done = 1'b0; i_Clr_Ovr = 1'b0;
      chk_state("ovf_set_vs_clr", 8, 1'b0, 1'b1, 8'h01, OVR_EN);
      i_Clr_Ovr = 1'b1;
      tick();
      i_Clr_Ovr = 1'b0;
      chk_state("ovr_clr", 8, 1'b0, 1'b1, 8'h01, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("drain1_%0d", i), 32'(o_Data), 32'(i));
         i_Rd = 1'b1;
         tick();
         i_Rd = 1'b0;
      end
      chk_state("drain1_end", 0, 1'b1, 1'b0, 8'h00, 1'b0);

      // Push and pop together while full.
      for (int i = 1; i <= 8; i++) push(8'(i));
      i_Data = 8'h55; i_Done = 1'b1; i_Rd = 1'b1;
      tick();
      i_Done = 1'b0; i_Rd = 1'b0;
      chk_state("full_pushpop", 8, 1'b0, 1'b1, 8'h02, 1'b0);
      tick();
      for (int i = 0; i < 8; i++) begin
         nd = (i == 7) ? 8'h55 : 8'(i + 2);
         chk($sformatf("drain2_%0d", i), 32'(o_Data), 32'(nd));
         i_Rd = 1'b1;
         tick();
         i_Rd = 1'b0;
      end
      chk_state("drain2_end", 0, 1'b1, 1'b0, 8'h00, 1'b0);

      // Twenty replace cycles at full occupancy walk both pointers around the array.
      q.delete();
      for (int i = 0; i < 8; i++) begin
         push(8'(8'h10 + i));
         q.push_back(8'(8'h10 + i));
      end
      for (int k = 0; k < 20; k++) begin
         nd = 8'(8'h20 + k);
         i_Data = nd; i_Done = 1'b1; i_Rd = 1'b1;
         tick();
         i_Done = 1'b0; i_Rd = 1'b0;
         void'(q.pop_front());
         q.push_back(nd);
         chk($sformatf("wrap%0d.count", k), 32'(o_Count), 32'd8);
         chk($sformatf("wrap%0d.data", k), 32'(o_Data), 32'(q[0]));
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain3_%0d", i), 32'(o_Data), 32'(q[i]));
         i_Rd = 1'b1;
         tick();
         i_Rd = 1'b0;
      end
      chk_state("drain3_end", 0, 1'b1, 1'b0, 8'h00, 1'b0);

      // Asynchronous reset mid-fill, then release with i_Done already high.
      push(8'hA1); push(8'hA2); push(8'hA3);
      chk_state("pre_rst", 3, 1'b0, 1'b0, 8'hA1, 1'b0);
      @(negedge i_Pclk);
      #2;
      i_Rst_n = 1'b0;
      #1;
      chk_state("async_rst", 0, 1'b1, 1'b0, 8'h00, 1'b0);
      i_Data = 8'hBB;
      i_Done = 1'b1;
      tick();
      @(negedge i_Pclk);
      i_Rst_n = 1'b1;
      tick();
      chk_state("rel_done_high", 0, 1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      chk_state("rel_done_held", 0, 1'b1, 1'b0, 8'h00, 1'b0);
      i_Done = 1'b0;
      tick();
      push(8'hCC);
      chk_state("post_rel_push", 1, 1'b0, 1'b0, 8'hCC, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
